// File: rtl/nios_dbg_cmd_pkg.sv
// Shared defaults, queue-entry type and helper functions for the debug command path.
// The optional parity check is enabled by defining NIOS_DBG_CMD_PARITY_EN.
package nios_dbg_cmd_pkg;

   localparam int IR_W_DEF    = 2;
   localparam int SR_W_DEF    = 38;
   localparam int NCH_DEF     = 4;
   localparam int DEPTH_DEF   = 4;
   localparam int SYNC_DEF    = 3;
   localparam int ACT_BIT_DEF = 35;
   localparam int MAX_CH      = 32;

   typedef struct packed {
      logic [IR_W_DEF-1:0] ir;
      logic [SR_W_DEF-1:0] sr;
   } cmd_entry_t;

   // One-hot channel select; all zero when the index is outside the populated channels.
   function automatic logic [MAX_CH-1:0] ch_decode(input logic [7:0] ch, input int unsigned nch);
      logic [MAX_CH-1:0] oh;
      if (32'(ch) < nch) begin
         oh = 32'd1 << ch;
      end else begin
         oh = '0;
      end
      return oh;
   endfunction

   function automatic logic par_odd(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/nios_dbg_cmd_sync_if.sv
// JTAG-side handshake and action-side strobe bundle of the debug command path.
// With NIOS_DBG_CMD_PARITY_EN defined, jtag_sr carries an extra even-parity MSB.
interface nios_dbg_cmd_sync_if
   import nios_dbg_cmd_pkg::*;
#(
   parameter int IR_W = IR_W_DEF,
   parameter int SR_W = SR_W_DEF,
   parameter int NCH  = NCH_DEF
);
`ifdef NIOS_DBG_CMD_PARITY_EN
   localparam int SRI_W = SR_W + 1;
`else
   localparam int SRI_W = SR_W;
`endif

   logic             jtag_req_tgl;
   logic [IR_W-1:0]  jtag_ir;
   logic [SRI_W-1:0] jtag_sr;
   logic             jtag_ack_tgl;
   logic             action_ready;
   logic [SR_W-1:0]  jdo;
   logic [NCH-1:0]   take_action;
   logic [NCH-1:0]   take_no_action;

   modport master (
      output jtag_req_tgl, jtag_ir, jtag_sr, action_ready,
      input  jtag_ack_tgl, jdo, take_action, take_no_action
   );

   modport slave (
      input  jtag_req_tgl, jtag_ir, jtag_sr, action_ready,
      output jtag_ack_tgl, jdo, take_action, take_no_action
   );

endinterface

// File: rtl/nios_dbg_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; pointers carry one extra bit to tell full from empty.
// The caller only asserts push when a slot is free (or a pop frees one in the same cycle).
module nios_dbg_cmd_fifo #(
   parameter  int WIDTH = 40,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage and pointer update; a reset flushes every entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r[AW-1:0]];
   assign count = wr_ptr_r - rd_ptr_r;
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/nios_dbg_cmd_sync.sv
// Debug command path: synchronises the tck request toggle, queues commands and issues
// per-channel strobes. NIOS_DBG_CMD_PARITY_EN adds a capture-time parity check and err_parity.
module nios_dbg_cmd_sync
   import nios_dbg_cmd_pkg::*;
#(
   parameter int IR_W        = IR_W_DEF,
   parameter int SR_W        = SR_W_DEF,
   parameter int NCH         = NCH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int SYNC_STAGES = SYNC_DEF,
   parameter int ACT_BIT     = ACT_BIT_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   nios_dbg_cmd_sync_if.slave       bus,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     err_overflow,
   output logic                     err_badch
`ifdef NIOS_DBG_CMD_PARITY_EN
   ,
   output logic                     err_parity
`endif
);

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [SR_W-1:0] sr;
   } entry_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;
   logic                   capture_s;
   logic                   par_ok_s;
   logic                   accept_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   drop_s;
   logic                   full_s;
   logic                   empty_s;
   entry_t                 wentry_s;
   entry_t                 head_s;
   logic [NCH-1:0]         dec_s;

   logic                   ack_r;
   logic [SR_W-1:0]        jdo_r;
   logic [NCH-1:0]         ta_r;
   logic [NCH-1:0]         tna_r;
   logic                   ovf_r;
   logic                   badch_r;

   // Request toggle synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], bus.jtag_req_tgl};
         hist_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign capture_s = sync_r[SYNC_STAGES-1] ^ hist_r;

   // Capture/issue decisions; a pop in the same cycle makes room for a push into a full queue.
   always_comb begin
`ifdef NIOS_DBG_CMD_PARITY_EN
      par_ok_s = ~par_odd(64'(bus.jtag_sr));
`else
      par_ok_s = 1'b1;
`endif
      pop_s       = ~empty_s & bus.action_ready;
      accept_s    = capture_s & par_ok_s;
      push_s      = accept_s & (~full_s | pop_s);
      drop_s      = accept_s & full_s & ~pop_s;
      wentry_s.ir = bus.jtag_ir;
      wentry_s.sr = bus.jtag_sr[SR_W-1:0];
      dec_s       = NCH'(ch_decode(8'(head_s.ir), NCH));
   end

   nios_dbg_cmd_fifo #(
      .WIDTH (IR_W + SR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .pop     (pop_s),
      .wdata   (wentry_s),
      .rdata   (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (q_count)
   );

   // Registered outputs: ack toggle, jdo, one-cycle strobes and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_r   <= 1'b0;
         jdo_r   <= '0;
         ta_r    <= '0;
         tna_r   <= '0;
         ovf_r   <= 1'b0;
         badch_r <= 1'b0;
      end else begin
         ack_r <= ack_r ^ capture_s;
         ovf_r <= ovf_r | drop_s;
         if (pop_s) begin
            jdo_r   <= head_s.sr;
            ta_r    <= head_s.sr[ACT_BIT] ? dec_s : '0;
            tna_r   <= head_s.sr[ACT_BIT] ? '0 : dec_s;
            badch_r <= badch_r | ~(|dec_s);
         end else begin
            ta_r  <= '0;
            tna_r <= '0;
         end
      end
   end

`ifdef NIOS_DBG_CMD_PARITY_EN
   logic par_err_r;

   // Sticky record of commands rejected for bad parity.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_err_r <= 1'b0;
      end else begin
         par_err_r <= par_err_r | (capture_s & ~par_ok_s);
      end
   end

   assign err_parity = par_err_r;
`endif

   assign bus.jtag_ack_tgl   = ack_r;
   assign bus.jdo            = jdo_r;
   assign bus.take_action    = ta_r;
   assign bus.take_no_action = tna_r;
   assign err_overflow       = ovf_r;
   assign err_badch          = badch_r;

endmodule

// File: tb/tb_nios_dbg_cmd_sync.sv
// Self-checking bench: a 4-channel and a 3-channel instance share one JTAG stimulus stream;
// vector table, hand sequences and randomized bursts checked against a queue-level model.
module tb_nios_dbg_cmd_sync;
   import nios_dbg_cmd_pkg::*;

   localparam int S     = 3;
   localparam int IR_W  = 2;
   localparam int SR_W  = 38;
   localparam int DEPTH = 4;
   localparam int ACT   = 35;
`ifdef NIOS_DBG_CMD_PARITY_EN
   localparam int SRI_W = SR_W + 1;
`else
   localparam int SRI_W = SR_W;
`endif

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] sr;
      logic [3:0]  ta;
      logic [3:0]  tna;
      logic [2:0]  ta3;
      logic [2:0]  tna3;
      logic        bad3;
   } vec_t;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] sr;
   } cmd_t;

   typedef struct {
      logic [3:0]  ta;
      logic [3:0]  tna;
      logic [37:0] jdo;
      int          cyc;
   } obs_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic req_tgl = 1'b0;
   logic [IR_W-1:0] ir = '0;
   logic [SR_W-1:0] sr_data = '0;
   logic [SRI_W-1:0] sr_drive;
   logic ready = 1'b0;
   logic [2:0] q4, q3;
   logic ovf4, ovf3, bad4, bad3;
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   bit model_ovf = 1'b0;
   obs_t obs[$];
   vec_t vt[5];

   always #5 clk = ~clk;

`ifdef NIOS_DBG_CMD_PARITY_EN
   logic par_flip = 1'b0;
   logic par4, par3;
   assign sr_drive = {(^sr_data) ^ par_flip, sr_data};
`else
   assign sr_drive = sr_data;
`endif

   nios_dbg_cmd_sync_if #(.IR_W(IR_W), .SR_W(SR_W), .NCH(4)) bus4 ();
   nios_dbg_cmd_sync_if #(.IR_W(IR_W), .SR_W(SR_W), .NCH(3)) bus3 ();

   assign bus4.jtag_req_tgl = req_tgl;
   assign bus4.jtag_ir      = ir;
   assign bus4.jtag_sr      = sr_drive;
   assign bus4.action_ready = ready;
   assign bus3.jtag_req_tgl = req_tgl;
   assign bus3.jtag_ir      = ir;
   assign bus3.jtag_sr      = sr_drive;
   assign bus3.action_ready = ready;

   nios_dbg_cmd_sync #(.IR_W(IR_W), .SR_W(SR_W), .NCH(4), .DEPTH(DEPTH),
                       .SYNC_STAGES(S), .ACT_BIT(ACT)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4), .q_count(q4),
      .err_overflow(ovf4), .err_badch(bad4)
`ifdef NIOS_DBG_CMD_PARITY_EN
      , .err_parity(par4)
`endif
   );

   nios_dbg_cmd_sync #(.IR_W(IR_W), .SR_W(SR_W), .NCH(3), .DEPTH(DEPTH),
                       .SYNC_STAGES(S), .ACT_BIT(ACT)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(bus3), .q_count(q3),
      .err_overflow(ovf3), .err_badch(bad3)
`ifdef NIOS_DBG_CMD_PARITY_EN
      , .err_parity(par3)
`endif
   );

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (reset_n && ((bus4.take_action | bus4.take_no_action) != 4'b0000)) begin
         obs.push_back('{ta: bus4.take_action, tna: bus4.take_no_action, jdo: bus4.jdo, cyc: cyc_n});
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Toggle the request and wait (bounded) for the returned ack toggle.
   task automatic send(input logic [IR_W-1:0] i, input logic [SR_W-1:0] d, output int n);
      ir = i;
      sr_data = d;
      req_tgl = ~req_tgl;
      n = 0;
      while (bus4.jtag_ack_tgl !== req_tgl && n < 20) begin
         cyc(1);
         n++;
      end
      check("ack_toggle", bus4.jtag_ack_tgl, req_tgl);
   endtask

   // Queue-level model: k commands with the consumer stalled, then a drain compared in order.
   task automatic round(input int k);
      cmd_t exp_q[$];
      cmd_t c;
      logic [63:0] r;
      int n;
      obs.delete();
      ready = 1'b0;
      for (int i = 0; i < k; i++) begin
         r = {$urandom, $urandom};
         c.ir = 2'($urandom_range(3, 0));
         c.sr = r[37:0];
         send(c.ir, c.sr, n);
         if (exp_q.size() < DEPTH) exp_q.push_back(c);
         else model_ovf = 1'b1;
      end
      check("q_count_stalled", q4, (k < DEPTH) ? k : DEPTH);
      check("err_overflow", ovf4, model_ovf);
      ready = 1'b1;
      cyc(DEPTH + 2);
      check("drain_count", obs.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < obs.size(); j++) begin
         check("drain_ta", obs[j].ta, exp_q[j].sr[ACT] ? (4'b0001 << exp_q[j].ir) : 4'b0000);
         check("drain_tna", obs[j].tna, exp_q[j].sr[ACT] ? 4'b0000 : (4'b0001 << exp_q[j].ir));
         check("drain_jdo", obs[j].jdo, exp_q[j].sr);
         check("drain_back_to_back", obs[j].cyc, obs[0].cyc + j);
      end
   endtask

   initial begin
      int n;
      cmd_t hand[5];

      vt[0] = '{2'd1, 38'h0A_1234_5678, 4'b0010, 4'b0000, 3'b010, 3'b000, 1'b0};
      vt[1] = '{2'd3, 38'h01_DEAD_BEEF, 4'b0000, 4'b1000, 3'b000, 3'b000, 1'b1};
      vt[2] = '{2'd0, 38'h08_0000_0001, 4'b0001, 4'b0000, 3'b001, 3'b000, 1'b1};
      vt[3] = '{2'd2, 38'h37_FFFF_FFFF, 4'b0000, 4'b0100, 3'b000, 3'b100, 1'b1};
      vt[4] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000, 3'b000, 3'b000, 1'b1};
      hand[0] = '{2'd0, 38'h08_0000_00A0};
      hand[1] = '{2'd1, 38'h00_0000_00B1};
      hand[2] = '{2'd2, 38'h08_0000_00C2};
      hand[3] = '{2'd3, 38'h00_0000_00D3};
      hand[4] = '{2'd1, 38'h08_0000_00E4};

      // Reset state
      cyc(3);
      check("rst_jdo", bus4.jdo, 38'h0);
      check("rst_strobes", {bus4.take_action, bus4.take_no_action}, 8'h00);
      check("rst_ack", bus4.jtag_ack_tgl, 1'b0);
      check("rst_q_count", {q4, q3}, 6'd0);
      check("rst_err", {ovf4, bad4, ovf3, bad3}, 4'b0000);
`ifdef NIOS_DBG_CMD_PARITY_EN
      check("rst_err_parity", par4, 1'b0);
`endif
      reset_n = 1'b1;
      ready = 1'b1;
      cyc(2);

      // Single commands: latency, strobe shape, jdo, bad-channel on the 3-channel instance
      for (int v = 0; v < 5; v++) begin
         send(vt[v].ir, vt[v].sr, n);
         check("ack_latency", n, S + 1);
         check("ack3", bus3.jtag_ack_tgl, req_tgl);
         check("pre_strobe", {bus4.take_action, bus4.take_no_action}, 8'h00);
         cyc(1);
         check("take_action", bus4.take_action, vt[v].ta);
         check("take_no_action", bus4.take_no_action, vt[v].tna);
         check("jdo", bus4.jdo, vt[v].sr);
         check("take_action_nch3", bus3.take_action, vt[v].ta3);
         check("take_no_action_nch3", bus3.take_no_action, vt[v].tna3);
         check("jdo_nch3", bus3.jdo, vt[v].sr);
         check("err_badch_nch3", bad3, vt[v].bad3);
         check("err_badch_nch4", bad4, 1'b0);
         cyc(1);
         check("strobe_one_cycle", {bus4.take_action, bus4.take_no_action}, 8'h00);
      end

      // Full queue with a pop landing on the capture cycle: push accepted, no overflow
      obs.delete();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) send(hand[i].ir, hand[i].sr, n);
      check("q_count_full", q4, 3'd4);
      ir = hand[4].ir;
      sr_data = hand[4].sr;
      req_tgl = ~req_tgl;
      cyc(S);
      ready = 1'b1;
      cyc(1);
      ready = 1'b0;
      check("pushpop_q_count", q4, 3'd4);
      check("pushpop_no_overflow", ovf4, 1'b0);
      check("pushpop_ack", bus4.jtag_ack_tgl, req_tgl);
      ready = 1'b1;
      cyc(6);
      check("pushpop_drain_count", obs.size(), 5);
      for (int j = 0; j < 5 && j < obs.size(); j++) begin
         check("pushpop_order_jdo", obs[j].jdo, hand[j].sr);
      end

      // Backpressure with one command too many, then randomized bursts
      round(5);
      for (int r = 0; r < 8; r++) round($urandom_range(6, 1));

`ifdef NIOS_DBG_CMD_PARITY_EN
      obs.delete();
      par_flip = 1'b1;
      send(2'd1, 38'h08_0000_0055, n);
      par_flip = 1'b0;
      cyc(3);
      check("err_parity", par4, 1'b1);
      check("parity_no_strobe", obs.size(), 0);
      check("parity_q_count", q4, 3'd0);
`endif

      // Reset asserted with commands queued
      ready = 1'b0;
      for (int i = 0; i < 3; i++) send(hand[i].ir, hand[i].sr, n);
      check("burst_q_count", q4, 3'd3);
      reset_n = 1'b0;
      req_tgl = 1'b0;
      #2;
      check("midrst_q_count", q4, 3'd0);
      check("midrst_strobes", {bus4.take_action, bus4.take_no_action}, 8'h00);
      check("midrst_ack", bus4.jtag_ack_tgl, 1'b0);
      check("midrst_err_overflow", ovf4, 1'b0);
      cyc(2);
      reset_n = 1'b1;
      ready = 1'b1;
      obs.delete();
      cyc(S + 4);
      check("midrst_flushed", obs.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
